vga_framebuffer_scanout: RTL and testbench



---
 rtl/vga_pkg.sv | 37 +++
 rtl/fb_ram_dp.sv | 32 +++
 rtl/vga_framebuffer_scanout.sv | 184 ++++++++++++++++++
 tb/tb_vga_framebuffer_scanout.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared constants, colour type and address helper for the frame-buffer scanout.
package vga_pkg;

  localparam int unsigned X_SCREEN_PIXELS = 160;
  localparam int unsigned Y_SCREEN_PIXELS = 120;
  localparam int unsigned FB_DEPTH        = X_SCREEN_PIXELS * Y_SCREEN_PIXELS;
  localparam int unsigned FB_ADDR_W       = 15;

  localparam int unsigned DEF_SCALE_LOG2  = 2;
  localparam int unsigned DEF_PIX_DIV     = 2;

  localparam int unsigned DEF_H_VISIBLE   = 640;
  localparam int unsigned DEF_H_FRONT     = 16;
  localparam int unsigned DEF_H_SYNC      = 96;
  localparam int unsigned DEF_H_BACK      = 48;
  localparam int unsigned DEF_V_VISIBLE   = 480;
  localparam int unsigned DEF_V_FRONT     = 10;
  localparam int unsigned DEF_V_SYNC      = 2;
  localparam int unsigned DEF_V_BACK      = 33;

  localparam int unsigned H_CNT_W         = 10;
  localparam int unsigned V_CNT_W         = 10;

  // {R,G,B}
  typedef logic [2:0] colour_t;

  // Linear address y*160 + x, built from shifts so no multiplier is needed.
  function automatic logic [FB_ADDR_W-1:0] fb_addr(input logic [FB_ADDR_W-1:0] x,
                                                   input logic [FB_ADDR_W-1:0] y);
    return (y << 7) + (y << 5) + x;
  endfunction

  function automatic logic [7:0] expand_bit(input logic b);
    return {8{b}};
  endfunction

endpackage

// File: rtl/fb_ram_dp.sv
// Simple dual-port frame-buffer RAM: one write port, one registered read-first read port.
module fb_ram_dp
  import vga_pkg::*;
#(
  parameter int unsigned DEPTH = FB_DEPTH
) (
  input  logic                 iClock,
  input  logic                 wr_en,
  input  logic [FB_ADDR_W-1:0] wr_addr,
  input  colour_t              wr_data,
  input  logic                 rd_en,
  input  logic [FB_ADDR_W-1:0] rd_addr,
  output colour_t              rd_data
);

  colour_t mem_r [DEPTH];

  // Write port; contents deliberately survive reset.
  always_ff @(posedge iClock) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Read port samples the array before any same-edge write lands (read-first).
  always_ff @(posedge iClock) begin
    if (rd_en) begin
      rd_data <= mem_r[rd_addr];
    end
  end

endmodule

// File: rtl/vga_framebuffer_scanout.sv
// Accepts pixel plots into a 160x120 frame buffer and scans it out as VGA,
// each stored pixel replicated to a (1<<SCALE_LOG2)-square screen block.
module vga_framebuffer_scanout
  import vga_pkg::*;
#(
  parameter int unsigned SCALE_LOG2 = DEF_SCALE_LOG2,
  parameter int unsigned PIX_DIV    = DEF_PIX_DIV,
  parameter int unsigned H_VISIBLE  = DEF_H_VISIBLE,
  parameter int unsigned H_FRONT    = DEF_H_FRONT,
  parameter int unsigned H_SYNC     = DEF_H_SYNC,
  parameter int unsigned H_BACK     = DEF_H_BACK,
  parameter int unsigned V_VISIBLE  = DEF_V_VISIBLE,
  parameter int unsigned V_FRONT    = DEF_V_FRONT,
  parameter int unsigned V_SYNC     = DEF_V_SYNC,
  parameter int unsigned V_BACK     = DEF_V_BACK
) (
  input  logic       iClock,
  input  logic       iResetn,
  input  logic [7:0] iX,
  input  logic [6:0] iY,
  input  colour_t    iColour,
  input  logic       iPlot,
  output logic [7:0] oVGA_R,
  output logic [7:0] oVGA_G,
  output logic [7:0] oVGA_B,
  output logic       oVGA_HS,
  output logic       oVGA_VS,
  output logic       oVGA_BLANK_N,
  output logic       oVGA_SYNC_N,
  output logic       oVGA_CLK,
  output logic       oFrameStart
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(PIX_DIV - 1);
  localparam logic [DIV_W-1:0]   DIV_HALF = DIV_W'(PIX_DIV / 2);
  localparam logic [H_CNT_W-1:0] H_LAST   = H_CNT_W'(H_TOTAL - 1);
  localparam logic [H_CNT_W-1:0] H_VIS    = H_CNT_W'(H_VISIBLE);
  localparam logic [H_CNT_W-1:0] HS_START = H_CNT_W'(H_VISIBLE + H_FRONT);
  localparam logic [H_CNT_W-1:0] HS_END   = H_CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [V_CNT_W-1:0] V_LAST   = V_CNT_W'(V_TOTAL - 1);
  localparam logic [V_CNT_W-1:0] V_VIS    = V_CNT_W'(V_VISIBLE);
  localparam logic [V_CNT_W-1:0] VS_START = V_CNT_W'(V_VISIBLE + V_FRONT);
  localparam logic [V_CNT_W-1:0] VS_END   = V_CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [DIV_W-1:0]     div_r;
  logic [DIV_W-1:0]     div_next_s;
  logic                 tick_s;
  logic                 vga_clk_r;
  logic [H_CNT_W-1:0]   hcount_r;
  logic [V_CNT_W-1:0]   vcount_r;
  logic                 h_wrap_s;
  logic                 v_wrap_s;
  logic                 frame_start_r;

  logic [H_CNT_W-1:0]   hx_s;
  logic [V_CNT_W-1:0]   vy_s;
  logic                 visible_s;
  logic                 hs_raw_s;
  logic                 vs_raw_s;
  logic [FB_ADDR_W-1:0] rd_addr_s;
  logic [FB_ADDR_W-1:0] wr_addr_s;
  logic                 wr_en_s;
  colour_t              rd_data_s;

  logic                 vis_d1_r;
  logic                 hs_d1_r;
  logic                 vs_d1_r;
  logic [7:0]           r_r;
  logic [7:0]           g_r;
  logic [7:0]           b_r;
  logic                 hs_r;
  logic                 vs_r;
  logic                 blank_n_r;

  // Pixel tick, counter wrap detection and stage-0 position decode.
  always_comb begin
    tick_s     = (div_r == DIV_LAST);
    div_next_s = tick_s ? {DIV_W{1'b0}} : (div_r + DIV_W'(1));
    h_wrap_s   = (hcount_r == H_LAST);
    v_wrap_s   = (vcount_r == V_LAST);
    hx_s       = hcount_r >> SCALE_LOG2;
    vy_s       = vcount_r >> SCALE_LOG2;
    visible_s  = (hcount_r < H_VIS) && (vcount_r < V_VIS);
    hs_raw_s   = !((hcount_r >= HS_START) && (hcount_r < HS_END));
    vs_raw_s   = !((vcount_r >= VS_START) && (vcount_r < VS_END));
    // Blanking positions map past the buffer, so they read a harmless address instead.
    rd_addr_s  = visible_s ? fb_addr(FB_ADDR_W'(hx_s), FB_ADDR_W'(vy_s))
                           : {FB_ADDR_W{1'b0}};
  end

  // Write-side qualification: in-range plots only, and never while held in reset.
  always_comb begin
    wr_en_s   = iPlot && iResetn &&
                (iX < 8'(X_SCREEN_PIXELS)) && (iY < 7'(Y_SCREEN_PIXELS));
    wr_addr_s = fb_addr(FB_ADDR_W'(iX), FB_ADDR_W'(iY));
  end

  fb_ram_dp #(
    .DEPTH (FB_DEPTH)
  ) u_fb_ram (
    .iClock  (iClock),
    .wr_en   (wr_en_s),
    .wr_addr (wr_addr_s),
    .wr_data (iColour),
    .rd_en   (tick_s),
    .rd_addr (rd_addr_s),
    .rd_data (rd_data_s)
  );

  // Clock divider and DAC pixel clock, high for the half period starting at each tick.
  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn) begin
      div_r     <= {DIV_W{1'b0}};
      vga_clk_r <= 1'b0;
    end else begin
      div_r     <= div_next_s;
      vga_clk_r <= (div_next_s < DIV_HALF);
    end
  end

  // Horizontal/vertical raster counters and frame-start pulse.
  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn) begin
      hcount_r      <= {H_CNT_W{1'b0}};
      vcount_r      <= {V_CNT_W{1'b0}};
      frame_start_r <= 1'b0;
    end else begin
      frame_start_r <= tick_s && h_wrap_s && v_wrap_s;
      if (tick_s) begin
        hcount_r <= h_wrap_s ? {H_CNT_W{1'b0}} : (hcount_r + H_CNT_W'(1));
        if (h_wrap_s) begin
          vcount_r <= v_wrap_s ? {V_CNT_W{1'b0}} : (vcount_r + V_CNT_W'(1));
        end
      end
    end
  end

  // Stage 1: timing flags delayed alongside the RAM read.
  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn) begin
      vis_d1_r <= 1'b0;
      hs_d1_r  <= 1'b1;
      vs_d1_r  <= 1'b1;
    end else if (tick_s) begin
      vis_d1_r <= visible_s;
      hs_d1_r  <= hs_raw_s;
      vs_d1_r  <= vs_raw_s;
    end
  end

  // Stage 2: output registers, colour forced dark outside the visible area.
  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn) begin
      r_r       <= 8'h00;
      g_r       <= 8'h00;
      b_r       <= 8'h00;
      hs_r      <= 1'b1;
      vs_r      <= 1'b1;
      blank_n_r <= 1'b0;
    end else if (tick_s) begin
      r_r       <= vis_d1_r ? expand_bit(rd_data_s[2]) : 8'h00;
      g_r       <= vis_d1_r ? expand_bit(rd_data_s[1]) : 8'h00;
      b_r       <= vis_d1_r ? expand_bit(rd_data_s[0]) : 8'h00;
      hs_r      <= hs_d1_r;
      vs_r      <= vs_d1_r;
      blank_n_r <= vis_d1_r;
    end
  end

  assign oVGA_R       = r_r;
  assign oVGA_G       = g_r;
  assign oVGA_B       = b_r;
  assign oVGA_HS      = hs_r;
  assign oVGA_VS      = vs_r;
  assign oVGA_BLANK_N = blank_n_r;
  assign oVGA_SYNC_N  = 1'b0;
  assign oVGA_CLK     = vga_clk_r;
  assign oFrameStart  = frame_start_r;

endmodule

// File: tb/tb_vga_framebuffer_scanout.sv
// Scoreboard bench for vga_framebuffer_scanout using a shortened raster so whole frames fit.
`timescale 1ns/1ps
module tb_vga_framebuffer_scanout;

  localparam int HV = 96, HF = 2, HSY = 4, HB = 2;
  localparam int VV = 136, VF = 1, VSY = 2, VB = 1;
  localparam int SC = 2, PD = 2;
  localparam int HT = HV + HF + HSY + HB;
  localparam int VT = VV + VF + VSY + VB;

  logic       iClock = 1'b0;
  logic       iResetn = 1'b0;
  logic [7:0] iX = 8'd0;
  logic [6:0] iY = 7'd0;
  logic [2:0] iColour = 3'd0;
  logic       iPlot = 1'b0;
  logic [7:0] oVGA_R, oVGA_G, oVGA_B;
  logic       oVGA_HS, oVGA_VS, oVGA_BLANK_N, oVGA_SYNC_N, oVGA_CLK, oFrameStart;

  always #5 iClock = ~iClock;

  vga_framebuffer_scanout #(
    .SCALE_LOG2(SC), .PIX_DIV(PD),
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VB)
  ) dut (
    .iClock(iClock), .iResetn(iResetn), .iX(iX), .iY(iY), .iColour(iColour), .iPlot(iPlot),
    .oVGA_R(oVGA_R), .oVGA_G(oVGA_G), .oVGA_B(oVGA_B), .oVGA_HS(oVGA_HS), .oVGA_VS(oVGA_VS),
    .oVGA_BLANK_N(oVGA_BLANK_N), .oVGA_SYNC_N(oVGA_SYNC_N), .oVGA_CLK(oVGA_CLK),
    .oFrameStart(oFrameStart)
  );

  typedef struct {
    int          f;
    int          h;
    int          v;
    logic [26:0] pins;
  } exp_t;

  exp_t       sb_q[$];
  logic [2:0] shadow [19200] = '{default: 3'd0};
  int         n_checks = 0, n_pass = 0;
  int         div_m = 0, hc = 0, vc = 0, frame_m = 0, tick_idx = 0;
  int         fs_count = 0, last_fs_tick = 0, blank0_count = 0;
  bit         sb_en = 1'b0, hs_seen = 1'b0;
  bit         tk, fs_exp, vis_m, hs_m, vs_m;
  logic [2:0] c_m;
  logic [23:0] rgb;
  exp_t       e, o;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference raster: push what each scanned position must show, compare 2 ticks on.
  always @(posedge iClock) begin
    if (!iResetn) begin
      div_m = 0; hc = 0; vc = 0; frame_m = 0; tick_idx = 0;
      sb_q.delete();
      e.f = -1; e.h = -1; e.v = -1; e.pins = {1'b1, 1'b1, 1'b0, 24'h000000};
      sb_q.push_back(e);
    end else begin
      tk = (div_m == PD - 1);
      if (tk) begin
        vis_m = (hc < HV) && (vc < VV);
        hs_m  = !((hc >= HV + HF) && (hc < HV + HF + HSY));
        vs_m  = !((vc >= VV + VF) && (vc < VV + VF + VSY));
        c_m   = vis_m ? shadow[(vc >> SC) * 160 + (hc >> SC)] : 3'd0;
        e.f = frame_m; e.h = hc; e.v = vc;
        e.pins = {hs_m, vs_m, vis_m, {8{c_m[2]}}, {8{c_m[1]}}, {8{c_m[0]}}};
        sb_q.push_back(e);
      end
      if (iPlot && iX < 8'd160 && iY < 7'd120) shadow[iY * 160 + iX] = iColour;
      fs_exp = tk && (hc == HT - 1) && (vc == VT - 1);
      if (tk) begin
        tick_idx++;
        if (hc == HT - 1) begin
          hc = 0;
          if (vc == VT - 1) begin vc = 0; frame_m++; end
          else vc++;
        end else hc++;
      end
      div_m = tk ? 0 : div_m + 1;
      #1;
      if (sb_en) begin
        check_eq("vga_clk", {31'd0, oVGA_CLK}, {31'd0, tk});
        check_eq("frame_start", {31'd0, oFrameStart}, {31'd0, fs_exp});
        if (oFrameStart) begin
          if (fs_count == 0) check_eq("first_frame_start", tick_idx, HT * VT);
          else check_eq("frame_ticks", tick_idx - last_fs_tick, HT * VT);
          fs_count++;
          last_fs_tick = tick_idx;
        end
        if (tk) begin
          o = sb_q.pop_front();
          rgb = {oVGA_R, oVGA_G, oVGA_B};
          check_eq($sformatf("pins f%0d h%0d v%0d", o.f, o.h, o.v),
                   {5'd0, oVGA_HS, oVGA_VS, oVGA_BLANK_N, rgb}, {5'd0, o.pins});
          if (o.f == 0 && oVGA_BLANK_N) blank0_count++;
          if (!hs_seen && !oVGA_HS) begin
            check_eq("hs_first_fall_ticks", tick_idx, HV + HF + 2);
            hs_seen = 1'b1;
          end
          if (o.f == 0 && o.h == 0 && o.v == 0) check_eq("collision_old", {24'd0, oVGA_G}, 32'h00);
          if (o.f == 0 && o.h == 1 && o.v == 0) check_eq("collision_after", {24'd0, oVGA_G}, 32'hFF);
          if (o.f == 1 && o.h == 0 && o.v == 0) check_eq("collision_next", {24'd0, oVGA_G}, 32'hFF);
          if (o.f <= 1 && o.h >= 40 && o.h <= 43 && o.v >= 20 && o.v <= 23)
            check_eq("single_write", {8'd0, rgb}, 32'hFF0000);
          if (o.f <= 1 && (o.h == 39 || o.h == 44) && o.v == 21)
            check_eq("single_neighbour", {8'd0, rgb}, 32'h0);
          if (o.f <= 1 && o.h <= 3 && o.v >= 4 && o.v <= 7)
            check_eq("oob_alias", {8'd0, rgb}, 32'h0);
          if (o.f <= 1 && o.h >= 8 && o.h <= 11 && o.v >= 8 && o.v <= 11)
            check_eq("reset_write_dropped", {8'd0, rgb}, 32'h0);
          if (o.f == 1 && o.h >= 80 && o.h <= 95 && o.v >= 120 && o.v <= 135)
            check_eq("burst_box", {8'd0, rgb}, 32'h00FFFF);
        end
      end else if (tk) begin
        void'(sb_q.pop_front());
      end
    end
  end

  task automatic plot(input int x, input int y, input int c);
    iX = 8'(x); iY = 7'(y); iColour = 3'(c); iPlot = 1'b1;
    @(negedge iClock);
  endtask

  initial begin
    int waited;
    repeat (4) @(negedge iClock);
    check_eq("reset_values",
             {22'd0, oVGA_HS, oVGA_VS, oVGA_BLANK_N, oVGA_SYNC_N, oVGA_CLK, oFrameStart,
              oVGA_R[1:0], oVGA_G[1:0], oVGA_B[1:0]},
             {22'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0});

    // Clear the visible part of the buffer, then mark one pixel to see scanout running.
    iResetn = 1'b1;
    for (int y = 0; y < 34; y++)
      for (int x = 0; x < 24; x++) plot(x, y, 0);
    plot(1, 8, 7);
    iPlot = 1'b0;
    waited = 0;
    while (oVGA_R !== 8'hFF && waited < 20000) begin
      @(negedge iClock);
      waited++;
    end
    check_eq("marker_seen", {24'd0, oVGA_R}, 32'hFF);

    iResetn = 1'b0;
    #1;
    check_eq("midframe_reset",
             {4'd0, oVGA_HS, oVGA_VS, oVGA_BLANK_N, oVGA_CLK, oVGA_R, oVGA_G, oVGA_B},
             {4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 24'h000000});
    @(negedge iClock);
    plot(2, 2, 7);
    plot(2, 2, 7);
    iPlot = 1'b0;
    @(negedge iClock);

    // Release; the second rising edge after this is the tick that reads address 0.
    sb_en = 1'b1;
    iResetn = 1'b1;
    @(negedge iClock);
    plot(0, 0, 2);
    plot(10, 5, 4);
    plot(160, 0, 7);
    plot(0, 120, 7);
    plot(159, 119, 7);
    for (int i = 0; i < 16; i++) plot(20 + (i % 4), 30 + (i / 4), 3);
    iPlot = 1'b0;

    repeat (2 * (2 * HT * VT) + 40) @(negedge iClock);
    check_eq("frame_start_count", fs_count, 2);
    check_eq("blank_high_ticks_frame0", blank0_count, HV * VV);
    check_eq("hs_fall_seen", {31'd0, hs_seen}, 32'd1);
    check_eq("queue_depth", sb_q.size(), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
